// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, one bit per cycle, valid/ready in and out.
// Optional signed-overflow output enabled by SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             result_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             ai;
  logic             bi;
  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] res_d;
  logic             last_bit;

  // Single full-subtractor cell operating on the LSBs of the shift registers.
  assign ai       = a_sr_q[0];
  assign bi       = b_sr_q[0];
  assign d_bit    = ai ^ bi ^ br_q;
  assign br_d     = (~ai & bi) | (~(ai ^ bi) & br_q);
  assign res_d    = {d_bit, res_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  assign start_ready  = (state_q == IDLE);
  assign result_valid = result_valid_q;
  assign diff         = diff_q;
  assign bout         = bout_q;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      a_sr_q         <= '0;
      b_sr_q         <= '0;
      res_q          <= '0;
      br_q           <= 1'b0;
      cnt_q          <= '0;
      result_valid_q <= 1'b0;
      diff_q         <= '0;
      bout_q         <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      a_msb_q        <= 1'b0;
      b_msb_q        <= 1'b0;
      ovf_q          <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            state_q <= SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          res_q  <= res_d;
          br_q   <= br_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_bit) begin
            // Outputs get their own copy so they hold through the next operation.
            cnt_q          <= '0;
            state_q        <= DONE;
            result_valid_q <= 1'b1;
            diff_q         <= res_d;
            bout_q         <= br_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            ovf_q          <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
